// File: rtl/request_sequencer_if.sv
// Memory handshake bundle between the sequencer and the imem/dmem ports.
// The sequencer takes the master side: it issues the requests and receives the hits and data.
interface request_sequencer_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmemload;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;

    modport master (
        input  ihit, imemload, dhit, dmemload,
        output imemREN, dmemREN, dmemWEN
    );

    modport slave (
        output ihit, imemload, dhit, dmemload,
        input  imemREN, dmemREN, dmemWEN
    );
endinterface

// File: rtl/request_sequencer.sv
// Multicycle FETCH/DECODE/MEM/COMMIT sequencer for the MIPS control unit and datapath,
// with a bus-hang watchdog, sticky halt/error flags and cycle/retire counters.
//
// state  | meaning
// FETCH  | imem read outstanding, waiting for ihit
// DECODE | control unit decodes instr_q, no requests
// MEM    | dmem read or write outstanding, waiting for dhit
// COMMIT | single-cycle PC advance and register writeback
// HALT   | absorbing until RST (HALT opcode or watchdog timeout)
module request_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    request_sequencer_if.master   mem,
    input  logic                  ctl_dREN,
    input  logic                  ctl_dWEN,
    input  logic                  ctl_RegWr,
    input  logic                  ctl_halt,
    output logic [31:0]           instr_q,
    output logic [31:0]           dload_q,
    output logic                  pc_en,
    output logic                  reg_wen,
    output logic                  halt,
    output logic                  mem_err,
    output logic                  illegal,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam int              WAIT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_instr;
    logic [31:0]       r_dload;
    logic              r_mem_err;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_retire;

    logic w_at_lim;
    logic w_timeout;
    logic w_is_store;
    logic w_is_load;

    // A store wins when both decode bits are set (illegal encoding).
    assign w_is_store = ctl_dWEN;
    assign w_is_load  = ctl_dREN & ~ctl_dWEN;
    assign w_at_lim   = (r_wait == WAIT_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem.ihit) begin
                    w_state_nxt = S_DECODE;
                end else if (w_at_lim) begin
                    w_state_nxt = S_HALT;
                    w_timeout   = 1'b1;
                end
            end
            S_DECODE: begin
                if (ctl_halt)
                    w_state_nxt = S_HALT;
                else if (ctl_dREN | ctl_dWEN)
                    w_state_nxt = S_MEM;
                else
                    w_state_nxt = S_COMMIT;
            end
            S_MEM: begin
                if (mem.dhit) begin
                    w_state_nxt = S_COMMIT;
                end else if (w_at_lim) begin
                    w_state_nxt = S_HALT;
                    w_timeout   = 1'b1;
                end
            end
            S_COMMIT: w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instr   <= '0;
            r_dload   <= '0;
            r_mem_err <= 1'b0;
            r_illegal <= 1'b0;
            r_cycle   <= '0;
            r_retire  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state)
                r_wait <= '0;
            else if ((r_state == S_FETCH) || (r_state == S_MEM))
                r_wait <= r_wait + 1'b1;

            if ((r_state == S_FETCH) && mem.ihit)
                r_instr <= mem.imemload;

            if ((r_state == S_MEM) && mem.dhit && w_is_load)
                r_dload <= mem.dmemload;

            if ((r_state == S_DECODE) && !ctl_halt && ctl_dREN && ctl_dWEN)
                r_illegal <= 1'b1;

            if (w_timeout)
                r_mem_err <= 1'b1;

            if (r_state != S_HALT)
                r_cycle <= r_cycle + 1'b1;

            if (r_state == S_COMMIT)
                r_retire <= r_retire + 1'b1;
        end
    end

    assign mem.imemREN = (r_state == S_FETCH);
    assign mem.dmemREN = (r_state == S_MEM) && w_is_load;
    assign mem.dmemWEN = (r_state == S_MEM) && w_is_store;

    assign pc_en      = (r_state == S_COMMIT);
    assign reg_wen    = (r_state == S_COMMIT) && ctl_RegWr;
    assign halt       = (r_state == S_HALT);
    assign instr_q    = r_instr;
    assign dload_q    = r_dload;
    assign mem_err    = r_mem_err;
    assign illegal    = r_illegal;
    assign cycle_cnt  = r_cycle;
    assign retire_cnt = r_retire;

endmodule

// File: tb/tb_request_sequencer.sv
// Directed bench for request_sequencer: per-scenario tasks with hand-computed expectations.
// DUT built with TIMEOUT=8 so the watchdog boundary is reachable quickly.
module tb_request_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ctl_dREN = 1'b0;
    logic        ctl_dWEN = 1'b0;
    logic        ctl_RegWr = 1'b0;
    logic        ctl_halt = 1'b0;
    logic [31:0] instr_q;
    logic [31:0] dload_q;
    logic        pc_en;
    logic        reg_wen;
    logic        halt;
    logic        mem_err;
    logic        illegal;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    request_sequencer_if bus ();

    request_sequencer #(.TIMEOUT(8), .CNT_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .mem        (bus),
        .ctl_dREN   (ctl_dREN),
        .ctl_dWEN   (ctl_dWEN),
        .ctl_RegWr  (ctl_RegWr),
        .ctl_halt   (ctl_halt),
        .instr_q    (instr_q),
        .dload_q    (dload_q),
        .pc_en      (pc_en),
        .reg_wen    (reg_wen),
        .halt       (halt),
        .mem_err    (mem_err),
        .illegal    (illegal),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.imemload = 32'h0; bus.dmemload = 32'h0;
        ctl_dREN = 1'b0; ctl_dWEN = 1'b0; ctl_RegWr = 1'b0; ctl_halt = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.imemREN !== 1'b1) begin n_fail++; $display("FAIL reset_imemREN: got %0b want 1", bus.imemREN); end
        n_cmp++; if ({bus.dmemREN, bus.dmemWEN, pc_en, reg_wen} !== 4'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0000", {bus.dmemREN, bus.dmemWEN, pc_en, reg_wen}); end
        n_cmp++; if ({halt, mem_err, illegal} !== 3'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {halt, mem_err, illegal}); end
        n_cmp++; if ({cycle_cnt, retire_cnt, instr_q, dload_q} !== 128'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {cycle_cnt, retire_cnt, instr_q, dload_q}); end
    endtask

    task automatic test_alu();
        do_reset();
        ctl_RegWr = 1'b1;
        bus.ihit = 1'b1; bus.imemload = 32'h012A4020;
        tick();
        bus.ihit = 1'b0;
        n_cmp++; if ({bus.imemREN, pc_en, reg_wen} !== 3'b000) begin n_fail++; $display("FAIL alu_decode_req: got %b want 000", {bus.imemREN, pc_en, reg_wen}); end
        n_cmp++; if (instr_q !== 32'h012A4020) begin n_fail++; $display("FAIL alu_instr_q: got %h want 012a4020", instr_q); end
        tick();
        n_cmp++; if ({pc_en, reg_wen} !== 2'b11) begin n_fail++; $display("FAIL alu_commit: got %b want 11", {pc_en, reg_wen}); end
        tick();
        n_cmp++; if ({pc_en, reg_wen, bus.imemREN} !== 3'b001) begin n_fail++; $display("FAIL alu_after: got %b want 001", {pc_en, reg_wen, bus.imemREN}); end
        n_cmp++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL alu_retire: got %0d want 1", retire_cnt); end
        n_cmp++; if (cycle_cnt !== 32'd3) begin n_fail++; $display("FAIL alu_cycles: got %0d want 3", cycle_cnt); end
    endtask

    task automatic test_load();
        int n_ren = 0, n_wen = 0, n_pc = 0;
        do_reset();
        ctl_dREN = 1'b1; ctl_RegWr = 1'b1;
        bus.imemload = 32'h8C220004; bus.dmemload = 32'hDEADBEEF;
        for (int c = 0; c < 9; c++) begin
            bus.ihit = (c == 2);
            bus.dhit = (c == 7);
            #0;
            n_ren += int'(bus.dmemREN);
            n_wen += int'(reg_wen);
            n_pc  += int'(pc_en);
            tick();
        end
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        n_cmp++; if (n_ren !== 4) begin n_fail++; $display("FAIL lw_dmemREN_cycles: got %0d want 4", n_ren); end
        n_cmp++; if (n_wen !== 1) begin n_fail++; $display("FAIL lw_reg_wen_pulses: got %0d want 1", n_wen); end
        n_cmp++; if (n_pc !== 1) begin n_fail++; $display("FAIL lw_pc_en_pulses: got %0d want 1", n_pc); end
        n_cmp++; if (dload_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_dload_q: got %h want deadbeef", dload_q); end
        n_cmp++; if (cycle_cnt !== 32'd9) begin n_fail++; $display("FAIL lw_cycles: got %0d want 9", cycle_cnt); end
        n_cmp++; if ({retire_cnt, bus.imemREN} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL lw_retire: got %0d/%0b want 1/1", retire_cnt, bus.imemREN); end
    endtask

    task automatic test_store();
        int n_wen = 0, n_ren = 0, n_rw = 0, n_pc = 0;
        do_reset();
        ctl_dWEN = 1'b1; ctl_RegWr = 1'b0;
        bus.imemload = 32'hAC220008; bus.dmemload = 32'h12345678;
        for (int c = 0; c < 5; c++) begin
            bus.ihit = (c == 0);
            bus.dhit = (c == 3);
            #0;
            n_wen += int'(bus.dmemWEN);
            n_ren += int'(bus.dmemREN);
            n_rw  += int'(reg_wen);
            n_pc  += int'(pc_en);
            tick();
        end
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        n_cmp++; if (n_wen !== 2) begin n_fail++; $display("FAIL sw_dmemWEN_cycles: got %0d want 2", n_wen); end
        n_cmp++; if (n_ren !== 0) begin n_fail++; $display("FAIL sw_dmemREN_cycles: got %0d want 0", n_ren); end
        n_cmp++; if (n_rw !== 0) begin n_fail++; $display("FAIL sw_reg_wen: got %0d want 0", n_rw); end
        n_cmp++; if (n_pc !== 1) begin n_fail++; $display("FAIL sw_pc_en_pulses: got %0d want 1", n_pc); end
        n_cmp++; if (dload_q !== 32'h0) begin n_fail++; $display("FAIL sw_dload_q_kept: got %h want 0", dload_q); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ctl_RegWr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.ihit = (c == 0) || (c == 3);
            bus.imemload = (c < 3) ? 32'h00000001 : 32'h00000002;
            tick();
        end
        bus.ihit = 1'b0;
        n_cmp++; if ({retire_cnt, cycle_cnt} !== {32'd2, 32'd6}) begin n_fail++; $display("FAIL b2b_counts: got %0d/%0d want 2/6", retire_cnt, cycle_cnt); end
        n_cmp++; if (instr_q !== 32'h00000002) begin n_fail++; $display("FAIL b2b_instr_q: got %h want 2", instr_q); end
    endtask

    task automatic test_halt();
        int n_req = 0;
        do_reset();
        ctl_halt = 1'b1; ctl_dREN = 1'b1;
        bus.ihit = 1'b1; bus.imemload = 32'hFFFFFFFF;
        tick();
        bus.ihit = 1'b0;
        tick();
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %0b want 1", halt); end
        for (int c = 0; c < 5; c++) begin
            bus.ihit = c[0];
            bus.dhit = 1'b1;
            bus.imemload = 32'h11111111;
            bus.dmemload = 32'h22222222;
            #0;
            n_req += int'(bus.imemREN) + int'(bus.dmemREN) + int'(bus.dmemWEN) + int'(pc_en) + int'(reg_wen);
            tick();
        end
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        n_cmp++; if (n_req !== 0) begin n_fail++; $display("FAIL halt_requests: got %0d want 0", n_req); end
        n_cmp++; if ({halt, cycle_cnt, retire_cnt} !== {1'b1, 32'd2, 32'd0}) begin n_fail++; $display("FAIL halt_frozen: got %0b/%0d/%0d want 1/2/0", halt, cycle_cnt, retire_cnt); end
        n_cmp++; if ({instr_q, dload_q} !== {32'hFFFFFFFF, 32'h0}) begin n_fail++; $display("FAIL halt_latches: got %h/%h want ffffffff/0", instr_q, dload_q); end
        n_cmp++; if ({mem_err, illegal} !== 2'b00) begin n_fail++; $display("FAIL halt_no_err: got %b want 00", {mem_err, illegal}); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 7; c++) tick();
        n_cmp++; if ({halt, mem_err, bus.imemREN} !== 3'b001) begin n_fail++; $display("FAIL to_before_limit: got %b want 001", {halt, mem_err, bus.imemREN}); end
        tick();
        n_cmp++; if ({halt, mem_err, bus.imemREN} !== 3'b110) begin n_fail++; $display("FAIL to_expired: got %b want 110", {halt, mem_err, bus.imemREN}); end
        n_cmp++; if (cycle_cnt !== 32'd8) begin n_fail++; $display("FAIL to_cycles: got %0d want 8", cycle_cnt); end

        do_reset();
        for (int c = 0; c < 7; c++) tick();
        bus.ihit = 1'b1; bus.imemload = 32'hCAFEF00D;
        tick();
        bus.ihit = 1'b0;
        n_cmp++; if ({halt, mem_err, bus.imemREN} !== 3'b000) begin n_fail++; $display("FAIL to_hit_wins: got %b want 000", {halt, mem_err, bus.imemREN}); end
        n_cmp++; if (instr_q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL to_hit_instr: got %h want cafef00d", instr_q); end
    endtask

    task automatic test_mem_timeout();
        do_reset();
        ctl_dREN = 1'b1;
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        tick();
        for (int c = 0; c < 7; c++) tick();
        n_cmp++; if ({halt, mem_err, bus.dmemREN} !== 3'b001) begin n_fail++; $display("FAIL memto_before: got %b want 001", {halt, mem_err, bus.dmemREN}); end
        tick();
        n_cmp++; if ({halt, mem_err, bus.dmemREN} !== 3'b110) begin n_fail++; $display("FAIL memto_expired: got %b want 110", {halt, mem_err, bus.dmemREN}); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        ctl_dREN = 1'b1; ctl_dWEN = 1'b1; ctl_RegWr = 1'b1;
        bus.ihit = 1'b1; bus.imemload = 32'h0BADC0DE;
        tick();
        bus.ihit = 1'b0;
        tick();
        n_cmp++; if ({bus.dmemWEN, bus.dmemREN, illegal} !== 3'b101) begin n_fail++; $display("FAIL illegal_store_wins: got %b want 101", {bus.dmemWEN, bus.dmemREN, illegal}); end
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_cmp++; if ({bus.dmemWEN, bus.imemREN} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_req: got %b want 01", {bus.dmemWEN, bus.imemREN}); end
        n_cmp++; if ({halt, mem_err, illegal} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 000", {halt, mem_err, illegal}); end
        n_cmp++; if ({cycle_cnt, retire_cnt, instr_q} !== 96'h0) begin n_fail++; $display("FAIL rst_mid_regs: got %h want 0", {cycle_cnt, retire_cnt, instr_q}); end
    endtask

    initial begin
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.imemload = 32'h0; bus.dmemload = 32'h0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_mem_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
